// File: rtl/lr_car_queue.sv
// Local-road car queue: synchronizes and debounces the loop sensor, counts queued cars,
// and retires one car per DEPART_CYCLES green edges. Optional macro: LR_QUEUE_WAIT_ALARM_EN.
module lr_car_queue #(
  parameter int DEB_CYCLES    = 3,
  parameter int DEPART_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor,
  input  logic [2:0] lr_light,
  output logic       lr_has_car,
  output logic [3:0] car_count,
  output logic       overflow,
  output logic       illegal_light,
  output logic       wait_alarm
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [3:0] DEP_LAST = 4'(DEPART_CYCLES - 1);

  logic       sync_q1, sync;
  logic       deb;
  logic [3:0] stab_cnt;
  logic [3:0] green_cnt;
  logic       is_green, one_hot;
  logic       arrival, departure;

  assign is_green  = (lr_light == 3'b100);
  assign one_hot   = (lr_light == 3'b100) | (lr_light == 3'b010) | (lr_light == 3'b001);
  // Arrival is the rising flip of deb, so it lands on the same edge deb changes.
  assign arrival   = !deb && sync && (stab_cnt == DEB_LAST);
  assign departure = is_green && (green_cnt == DEP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync    <= 1'b0;
    end else begin
      sync_q1 <= sensor;
      sync    <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb      <= 1'b0;
      stab_cnt <= '0;
    end else if (sync == deb) begin
      stab_cnt <= '0;
    end else if (stab_cnt == DEB_LAST) begin
      stab_cnt <= '0;
      deb      <= ~deb;
    end else begin
      stab_cnt <= stab_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        green_cnt <= '0;
    else if (!is_green || departure)   green_cnt <= '0;
    else                               green_cnt <= green_cnt + 4'd1;
  end

  // A coincident arrival and departure nets to zero, and since a slot frees up
  // in the same edge no car is lost, so overflow is not raised then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_count <= '0;
      overflow  <= 1'b0;
    end else begin
      case ({arrival, departure})
        2'b10: begin
          if (car_count == 4'hF) overflow  <= 1'b1;
          else                   car_count <= car_count + 4'd1;
        end
        2'b01: if (car_count != 4'h0) car_count <= car_count - 4'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_light <= 1'b0;
    else        illegal_light <= !one_hot;
  end

  assign lr_has_car = |car_count;

`ifdef LR_QUEUE_WAIT_ALARM_EN
  logic       is_red;
  logic [4:0] wait_tmr;

  assign is_red = (lr_light == 3'b001);

  // Timer saturates at 16; the alarm rises on the edge the timer reaches 16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_tmr   <= '0;
      wait_alarm <= 1'b0;
    end else if (!(lr_has_car && is_red)) begin
      wait_tmr   <= '0;
      wait_alarm <= 1'b0;
    end else begin
      if (wait_tmr != 5'd16) wait_tmr <= wait_tmr + 5'd1;
      if (wait_tmr >= 5'd15) wait_alarm <= 1'b1;
    end
  end
`else
  assign wait_alarm = 1'b0;
`endif

endmodule

// File: doc/lr_car_queue.md
LR_CAR_QUEUE -- requirements
Module: lr_car_queue

Interface
REQ-001 The block SHALL have a parameter DEB_CYCLES, default 3: the number of consecutive stable synchronized samples needed to change the debounced sensor level (legal range 1..15).
REQ-002 The block SHALL have a parameter DEPART_CYCLES, default 2: the number of consecutive green-sampled edges per car departure (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port sensor, input, 1 bit: the raw local-road loop detector, asynchronous to clk; high means a vehicle is over the loop.
REQ-006 The block SHALL have port lr_light, input, 3 bits: the local-road light from the controller, encoded 3'b100 green, 3'b010 yellow, 3'b001 red.
REQ-007 The block SHALL have port lr_has_car, output, 1 bit: the car-waiting request to the traffic light controller.
REQ-008 The block SHALL have port car_count, output, 4 bits: the number of queued local-road cars.
REQ-009 The block SHALL have port overflow, output, 1 bit: a sticky flag indicating an arrival was lost at a full queue.
REQ-010 The block SHALL have port illegal_light, output, 1 bit: a one-cycle pulse when lr_light is not one-hot.
REQ-011 The block SHALL have port wait_alarm, output, 1 bit: a starvation alarm (see Configuration).

Function
REQ-012 The block SHALL pass sensor through a 2-flop synchronizer; the second flop's output is the synchronized value, sync.
REQ-013 The debounced level deb SHALL flip on the DEB_CYCLES-th consecutive edge at which sync differs from deb; any edge where sync equals deb clears the stability counter.
REQ-014 An arrival SHALL be the edge on which deb flips 0->1; with defaults, if sensor is first sampled high on edge 1 and held, car_count increments on edge 5.
REQ-015 A green cycle counter SHALL advance on each edge sampling lr_light==3'b100 and clear on any other sampled value.
REQ-016 A departure SHALL occur on the edge where the green cycle counter reaches DEPART_CYCLES, and the counter SHALL then restart at 0 (defaults: 2nd, 4th, 6th... consecutive green edge).
REQ-017 car_count SHALL be +1 on arrival only, -1 on departure only, and unchanged on simultaneous arrival and departure.
REQ-018 Arrival at car_count==15 SHALL leave car_count at 15 and set overflow, which remains set until reset.
REQ-019 Departure at car_count==0 SHALL be ignored: the count does not wrap and no flag is raised.
REQ-020 lr_has_car SHALL equal (car_count != 0), derived from the count register with no extra cycle of latency.
REQ-021 illegal_light SHALL be registered, high for exactly the cycle after each edge sampling a non-one-hot lr_light (including 3'b000), and SHALL not affect counting.

Reset
REQ-022 rst_n low SHALL immediately clear the synchronizer, deb, stability counter, green counter, car_count, overflow, illegal_light and wait_alarm to 0, and therefore lr_has_car to 0.
REQ-023 Reset asserted mid-operation (queue non-empty, debounce in progress) SHALL discard all pending state, and no arrival SHALL be generated by the deb 0 state after release.
REQ-024 After rst_n rises, normal operation SHALL resume on the first rising clk edge.

Configuration
REQ-025 With macro LR_QUEUE_WAIT_ALARM_EN defined, a 5-bit wait timer SHALL count edges where lr_has_car==1 and lr_light==3'b001, clear otherwise, and assert wait_alarm (sticky until the timer clears) once it reaches 16.
REQ-026 Without LR_QUEUE_WAIT_ALARM_EN, no timer logic SHALL be built and wait_alarm SHALL be tied to 0.

Verification
REQ-027 Reset release, sensor high held from edge 1 -> car_count 0->1 and lr_has_car 0->1 on edge 5; sensor low for 2 edges then high again -> no new arrival.
REQ-028 Three debounced arrivals, then lr_light=3'b100 for 6 edges -> car_count 3,2,1,0 on green edges 2,4,6; lr_has_car low after edge 6.
REQ-029 16 debounced arrivals with lr_light red -> car_count saturates at 15 and overflow sets on the 16th arrival and stays set.
REQ-030 Arrival edge coinciding with a departure edge -> car_count unchanged; lr_light=3'b110 for one edge -> illegal_light high for one cycle.
REQ-031 rst_n pulsed low mid-cycle with car_count=7 -> all outputs 0 immediately, before any clk edge.
REQ-032 With LR_QUEUE_WAIT_ALARM_EN: 1 car queued and lr_light red for 16 edges -> wait_alarm=1; lr_light green -> wait_alarm=0. Without the macro -> wait_alarm stays 0.
